// File: rtl/dcache_ctrl.sv
// Data cache sequencer: hit service, write-back and fill bursts on the nibble bus, flush walk.
// Optional burst watchdog enabled by defining DCACHE_CTRL_TIMEOUT_EN.
module dcache_ctrl #(
   parameter int LINE_LENGTH = 4,
   parameter int NLINES      = 4,
   parameter int PA          = 22
`ifdef DCACHE_CTRL_TIMEOUT_EN
   , parameter int TO_BITS   = 6
`endif
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [PA-2:0]                     cpu_paddr,
   input  logic [1:0]                        cpu_read,
   input  logic [1:0]                        cpu_write,
   input  logic                              cpu_fault,
   output logic                              cpu_ready,
   output logic                              cpu_err,
   input  logic                              flush_req,
   output logic                              flush_done,
   output logic [PA-2:0]                     c_paddr,
   output logic [1:0]                        c_read,
   output logic [1:0]                        c_write,
   output logic                              c_fault,
   output logic                              c_flush_write,
   output logic                              c_flush_all,
   input  logic                              c_hit,
   input  logic                              c_push,
   input  logic                              c_pull,
   input  logic [PA-$clog2(LINE_LENGTH)-1:0] c_tag,
   output logic                              c_wstrobe_d,
   output logic                              c_rstrobe_d,
   output logic                              mem_req,
   output logic                              mem_wr,
   output logic [PA-$clog2(LINE_LENGTH)-1:0] mem_addr,
   input  logic                              mem_ack,
   input  logic                              mem_strobe
);

   localparam int BEATS = 2 * LINE_LENGTH;
   localparam int OFFB  = $clog2(LINE_LENGTH);
   localparam int IDXB  = $clog2(NLINES);
   localparam int CNTB  = $clog2(BEATS);
   localparam int TAGW  = PA - OFFB;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WB    = 3'd1,
      FILL  = 3'd2,
      FSCAN = 3'd3,
      FWB   = 3'd4,
      FCLR  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [CNTB-1:0]   cnt_q, cnt_d;
   logic [IDXB-1:0]   idx_q, idx_d;
   logic [TAGW-1:0]   tag_q, tag_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_wr_q, mem_wr_d;
   logic              req, burst, last_beat, flushing, to_hit;
   logic              ready_c, err_c, done_c, fall_c;

   assign req       = (|cpu_read) || (|cpu_write);
   assign burst     = (state_q == WB) || (state_q == FILL) || (state_q == FWB);
   assign last_beat = burst && mem_strobe && (cnt_q == CNTB'(BEATS-1));
   assign flushing  = (state_q == FSCAN) || (state_q == FWB) || (state_q == FCLR);

`ifdef DCACHE_CTRL_TIMEOUT_EN
   logic [TO_BITS-1:0] wd_q;

   // Watchdog counts strobe-free cycles once the bus has granted the burst.
   assign to_hit = burst && !mem_req_q && !mem_strobe && (wd_q == {TO_BITS{1'b1}});

   always_ff @(posedge clk) begin
      if (reset || !burst || mem_req_q || mem_strobe || to_hit) begin
         wd_q <= {TO_BITS{1'b0}};
      end else begin
         wd_q <= wd_q + TO_BITS'(1);
      end
   end
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= {CNTB{1'b0}};
         idx_q     <= {IDXB{1'b0}};
         tag_q     <= {TAGW{1'b0}};
         mem_req_q <= 1'b0;
         mem_wr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         tag_q     <= tag_d;
         mem_req_q <= mem_req_d;
         mem_wr_q  <= mem_wr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      tag_d     = tag_q;
      mem_req_d = mem_req_q && !mem_ack;
      mem_wr_d  = mem_wr_q;
      ready_c   = 1'b0;
      err_c     = 1'b0;
      done_c    = 1'b0;
      fall_c    = 1'b0;
      // The cache restarts its offset on any gap, so a partial burst must restart from beat 0.
      if (burst) begin
         if (last_beat || !mem_strobe) begin
            cnt_d = {CNTB{1'b0}};
         end else begin
            cnt_d = cnt_q + CNTB'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
      case (state_q)
         IDLE: begin
            if (req) begin
               if (cpu_fault) begin
                  ready_c = 1'b1;
                  err_c   = 1'b1;
               end else if (c_hit) begin
                  ready_c = 1'b1;
               end else if (c_push || c_pull) begin
                  state_d   = c_push ? WB : FILL;
                  tag_d     = c_tag;
                  mem_req_d = 1'b1;
                  mem_wr_d  = c_push;
                  cnt_d     = {CNTB{1'b0}};
               end else begin
                  state_d = IDLE;
               end
            end else if (flush_req) begin
               state_d = FSCAN;
               idx_d   = {IDXB{1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         WB, FILL: begin
            if (to_hit) begin
               state_d   = IDLE;
               ready_c   = 1'b1;
               err_c     = 1'b1;
               mem_req_d = 1'b0;
               cnt_d     = {CNTB{1'b0}};
            end else if (last_beat) begin
               state_d = IDLE;
               ready_c = (state_q == FILL) && (|cpu_write);
            end else begin
               state_d = state_q;
            end
         end
         FSCAN: begin
            if (c_push) begin
               state_d   = FWB;
               tag_d     = c_tag;
               mem_req_d = 1'b1;
               mem_wr_d  = 1'b1;
               cnt_d     = {CNTB{1'b0}};
            end else if (idx_q == IDXB'(NLINES-1)) begin
               state_d = FCLR;
            end else begin
               idx_d = idx_q + IDXB'(1);
            end
         end
         FWB: begin
            if (to_hit) begin
               state_d   = FCLR;
               mem_req_d = 1'b0;
               cnt_d     = {CNTB{1'b0}};
            end else if (last_beat) begin
               state_d = FSCAN;
            end else begin
               state_d = FWB;
            end
         end
         FCLR: begin
            fall_c  = 1'b1;
            done_c  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Flush states drive only the index field so the cache walks its lines by position.
   always_comb begin
      c_paddr       = cpu_paddr;
      c_read        = cpu_read;
      c_write       = cpu_write;
      c_fault       = cpu_fault;
      c_flush_write = 1'b0;
      if (flushing) begin
         c_paddr                  = {(PA-1){1'b0}};
         c_paddr[OFFB-1 +: IDXB]  = idx_q;
         c_read                   = 2'b00;
         c_write                  = 2'b00;
         c_fault                  = 1'b0;
         c_flush_write            = 1'b1;
      end else begin
         c_flush_write = 1'b0;
      end
   end

   assign cpu_ready   = ready_c && !reset;
   assign cpu_err     = err_c && !reset;
   assign flush_done  = done_c && !reset;
   assign c_flush_all = fall_c && !reset;
   assign c_rstrobe_d = mem_strobe && ((state_q == WB) || (state_q == FWB)) && !reset;
   assign c_wstrobe_d = mem_strobe && (state_q == FILL) && !reset;
   assign mem_req     = mem_req_q;
   assign mem_wr      = mem_wr_q;
   assign mem_addr    = tag_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a small 4-line cache model answering hit/push/pull.
module tb_dcache_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [20:0] cpu_paddr;
   logic [1:0]  cpu_read, cpu_write;
   logic        cpu_fault, cpu_ready, cpu_err, flush_req, flush_done;
   logic [20:0] c_paddr;
   logic [1:0]  c_read, c_write;
   logic        c_fault, c_flush_write, c_flush_all;
   logic        c_hit, c_push, c_pull;
   logic [19:0] c_tag;
   logic        c_wstrobe_d, c_rstrobe_d, mem_req, mem_wr;
   logic [19:0] mem_addr;
   logic        mem_ack, mem_strobe;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dcache_ctrl dut (
      .clk(clk), .reset(reset), .cpu_paddr(cpu_paddr), .cpu_read(cpu_read),
      .cpu_write(cpu_write), .cpu_fault(cpu_fault), .cpu_ready(cpu_ready),
      .cpu_err(cpu_err), .flush_req(flush_req), .flush_done(flush_done),
      .c_paddr(c_paddr), .c_read(c_read), .c_write(c_write), .c_fault(c_fault),
      .c_flush_write(c_flush_write), .c_flush_all(c_flush_all), .c_hit(c_hit),
      .c_push(c_push), .c_pull(c_pull), .c_tag(c_tag), .c_wstrobe_d(c_wstrobe_d),
      .c_rstrobe_d(c_rstrobe_d), .mem_req(mem_req), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_strobe(mem_strobe)
   );

   // Cache model: line index = byte addr [3:2], tag = byte addr [21:4].
   logic        pv [4];
   logic        pd [4];
   logic [17:0] pt [4];
   logic        mv [4];
   logic        md [4];
   logic [17:0] mt [4];
   logic [1:0]  mi;
   int          run, fills, wsn, rsn, reqs;

   assign mi = c_paddr[2:1];

   always_comb begin
      c_hit  = mv[mi] && (mt[mi] == c_paddr[20:3]) && ((|c_read) || (|c_write));
      c_push = !c_hit && mv[mi] && md[mi];
      c_pull = !c_hit && !c_push;
      c_tag  = c_push ? {mt[mi], mi} : c_paddr[20:1];
   end

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            mv[i] <= pv[i];
            md[i] <= pd[i];
            mt[i] <= pt[i];
         end
         run <= 0; fills <= 0; wsn <= 0; rsn <= 0; reqs <= 0;
      end else begin
         if (mem_req) reqs <= reqs + 1;
         if (c_wstrobe_d) begin
            wsn <= wsn + 1;
            if (run == 7) begin
               run <= 0; mv[mi] <= 1'b1; mt[mi] <= c_paddr[20:3]; md[mi] <= |c_write;
               fills <= fills + 1;
            end else run <= run + 1;
         end else if (c_rstrobe_d) begin
            rsn <= rsn + 1;
            if (run == 7) begin
               run <= 0; md[mi] <= 1'b0;
            end else run <= run + 1;
         end else run <= 0;
         if (cpu_ready && !cpu_err && c_hit && (|c_write)) md[mi] <= 1'b1;
         if (c_flush_all) for (int i = 0; i < 4; i++) mv[i] <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic set_addr(input logic [21:0] baddr);
      cpu_paddr = baddr[21:1];
   endtask

   task automatic do_reset();
      reset = 1'b1; cpu_read = 2'b00; cpu_write = 2'b00; cpu_fault = 1'b0;
      flush_req = 1'b0; mem_ack = 1'b0; mem_strobe = 1'b0; cpu_paddr = 21'h0;
      cyc(); cyc();
      reset = 1'b0;
      #1;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!mem_req && n < 20) begin
         cyc();
         n++;
      end
      check({tag, "_req"}, mem_req, 1'b1);
   endtask

   task automatic burst(input string tag, input logic exp_wr, input logic [19:0] exp_addr,
                        input logic [15:0] pat, input int n, input logic exp_last);
      wait_req(tag);
      check({tag, "_wr"}, mem_wr, exp_wr);
      check({tag, "_addr"}, mem_addr, exp_addr);
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
      #1;
      check({tag, "_reqdrop"}, mem_req, 1'b0);
      for (int i = 0; i < n; i++) begin
         mem_strobe = pat[i];
         #1;
         check({tag, "_rdy"}, cpu_ready, (i == n-1) ? exp_last : 1'b0);
         cyc();
      end
      mem_strobe = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int r0, n;
      for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pd[i] = 1'b0; pt[i] = 18'h0; end

      // Reset, read hit at 0x10, fault
      pv[0] = 1'b1; pt[0] = 18'h1;
      reset = 1'b1;
      do_reset();
      check("rst_ready", cpu_ready, 1'b0);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_flush_done", flush_done, 1'b0);
      check("rst_flush_wr", c_flush_write, 1'b0);
      r0 = reqs;
      set_addr(22'h10); cpu_read = 2'b01;
      #1;
      check("hit_ready", cpu_ready, 1'b1);
      check("hit_err", cpu_err, 1'b0);
      cyc(); cpu_read = 2'b00; cyc();
      check("hit_no_req", reqs - r0, 0);
      set_addr(22'h40); cpu_read = 2'b10; cpu_fault = 1'b1;
      #1;
      check("fault_ready", cpu_ready, 1'b1);
      check("fault_err", cpu_err, 1'b1);
      cyc(); cpu_read = 2'b00; cpu_fault = 1'b0; cyc();
      check("fault_no_req", mem_req, 1'b0);

      // Read miss on clean line 0x120
      set_addr(22'h120); cpu_read = 2'b11;
      #1;
      check("rmiss_ready0", cpu_ready, 1'b0);
      burst("rmiss", 1'b0, 20'h48, 16'h00FF, 8, 1'b0);
      #1;
      check("rmiss_done", cpu_ready, 1'b1);
      check("rmiss_wstrobes", wsn, 8);
      cyc(); cpu_read = 2'b00;

      // Store miss on dirty line 0x30, new line 0x200
      pd[0] = 1'b1; pt[0] = 18'hC;
      do_reset();
      set_addr(22'h200); cpu_write = 2'b11;
      burst("wb", 1'b1, 20'h30, 16'h00FF, 8, 1'b0);
      check("wb_rstrobes", rsn, 8);
      burst("sfill", 1'b0, 20'h80, 16'h00FF, 8, 1'b1);
      cpu_write = 2'b00;
      #1;
      check("sfill_valid", mv[0], 1'b1);
      check("sfill_tag", mt[0], 18'h20);
      check("sfill_dirty", md[0], 1'b1);
      check("sfill_ready_after", cpu_ready, 1'b0);

      // Fill with a gap after 3 beats, then a full restart
      for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pd[i] = 1'b0; end
      do_reset();
      set_addr(22'h348); cpu_read = 2'b01;
      burst("gap", 1'b0, 20'hD2, 16'h0FF7, 12, 1'b0);
      #1;
      check("gap_done", cpu_ready, 1'b1);
      check("gap_fills", fills, 1);
      check("gap_wstrobes", wsn, 11);
      check("gap_req_idle", mem_req, 1'b0);
      cyc(); cpu_read = 2'b00;

      // Flush walk with lines 1 and 3 dirty; CPU request wins over flush_req
      for (int i = 0; i < 4; i++) pv[i] = 1'b1;
      pd[1] = 1'b1; pd[3] = 1'b1;
      pt[0] = 18'h1; pt[1] = 18'h5; pt[2] = 18'h2; pt[3] = 18'h7;
      do_reset();
      set_addr(22'h10); cpu_read = 2'b01; flush_req = 1'b1;
      #1;
      check("prio_ready", cpu_ready, 1'b1);
      check("prio_no_flush", c_flush_write, 1'b0);
      cyc(); cpu_read = 2'b00; cyc();
      #1;
      check("fscan_flush_wr", c_flush_write, 1'b1);
      check("fscan_paddr", c_paddr, 21'h0);
      burst("fwb1", 1'b1, 20'h15, 16'h00FF, 8, 1'b0);
      burst("fwb3", 1'b1, 20'h1F, 16'h00FF, 8, 1'b0);
      n = 0;
      while (!flush_done && n < 20) begin cyc(); n++; end
      check("flush_done", flush_done, 1'b1);
      check("flush_all", c_flush_all, 1'b1);
      check("flush_rstrobes", rsn, 16);
      flush_req = 1'b0;
      cyc();
      #1;
      check("flush_done_pulse", flush_done, 1'b0);
      check("flush_all_pulse", c_flush_all, 1'b0);
      set_addr(22'h10); cpu_read = 2'b01;
      #1;
      check("post_flush_miss", c_hit, 1'b0);
      check("post_flush_ready", cpu_ready, 1'b0);
      cyc();
      check("post_flush_fill", mem_req, 1'b1);

      // Reset in the middle of a burst
      cpu_read = 2'b00; reset = 1'b1;
      cyc(); reset = 1'b0; cyc();
      #1;
      check("midrst_req", mem_req, 1'b0);
      check("midrst_strobe", c_wstrobe_d, 1'b0);

`ifdef DCACHE_CTRL_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pd[i] = 1'b0; end
      do_reset();
      set_addr(22'h120); cpu_read = 2'b01;
      wait_req("to");
      mem_ack = 1'b1; cyc(); mem_ack = 1'b0;
      n = 1;
      while (!cpu_ready && n < 200) begin cyc(); n++; end
      check("to_cycles", n, 64);
      check("to_err", cpu_err, 1'b1);
      cpu_read = 2'b00;
      cyc();
      check("to_req_low", mem_req, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Sequencer for the nibble-serial data cache. Owns the cache address mux and read/write qualifiers, and turns CPU load/store requests into hit service, line write-back and line fill bursts on the 4-bit external memory bus.
- Runs a full write-back flush walk on request.
- Sits between the CPU load/store unit, the data cache and the external memory arbiter.

Parameters:
- LINE_LENGTH, 4, cache line bytes; a burst is BEATS=2*LINE_LENGTH nibbles.
- NLINES, 4, cache lines; the flush walk visits each index once.
- PA, 22, physical address width (byte address bits PA-1:1 carried).
- TO_BITS, 6, watchdog width (optional feature only).

Ports:
- clk in 1: clock.
- reset in 1: synchronous, active-high.
- cpu_paddr in PA-1: CPU address, bits PA-1:1.
- cpu_read in 2: byte-lane read request, held until cpu_ready.
- cpu_write in 2: byte-lane write request, held until cpu_ready.
- cpu_fault in 1: MMU fault for the current request.
- cpu_ready out 1: request complete this cycle.
- cpu_err out 1: request aborted, valid with cpu_ready.
- flush_req in 1: start flush walk, held until flush_done.
- flush_done out 1: one-cycle pulse at end of walk.
- c_paddr out PA-1: address to cache.
- c_read out 2: read qualifier to cache.
- c_write out 2: write qualifier to cache.
- c_fault out 1: fault qualifier to cache.
- c_flush_write out 1: flush-write qualifier to cache.
- c_flush_all out 1: flush-all qualifier to cache.
- c_hit in 1: cache status.
- c_push in 1: cache status.
- c_pull in 1: cache status.
- c_tag in PA-log2(LINE_LENGTH): cache status.
- c_wstrobe_d out 1: fill-beat strobe to cache.
- c_rstrobe_d out 1: write-back-beat strobe to cache.
- mem_req out 1: bus request.
- mem_wr out 1: 1 = write-back, 0 = fill.
- mem_addr out PA-log2(LINE_LENGTH): line address.
- mem_ack in 1: grant, one pulse.
- mem_strobe in 1: one nibble transferred this cycle (data itself flows cache<->memory directly).

Behaviour:
- Reset values (cleared same edge): state=IDLE; all outputs 0 (cpu_ready, cpu_err, flush_done, mem_req, mem_wr, strobes, c_flush_*); beat counter 0; flush index 0.
- State set: IDLE, WB, FILL, FSCAN, FWB, FCLR.
- Cache address mux: in IDLE/WB/FILL, c_paddr=cpu_paddr and c_read/c_write/c_fault pass through. In flush states, c_paddr index field = flush index, other bits 0, c_read=c_write=0, c_flush_write=1.
- IDLE, request present (any cpu_read/cpu_write bit), flush_req low:
  - cpu_fault: cpu_ready=cpu_err=1 same cycle; no cache or bus activity.
  - else c_hit: cpu_ready=1 same cycle (combinational); the cache commits the store at that edge.
  - else c_push: go to WB.
  - else c_pull: go to FILL.
  - flush_req is accepted only with no CPU request pending, then go to FSCAN. A CPU request and flush_req together: CPU served first.
- WB / FILL:
  - mem_req=1, mem_wr=1 in WB / 0 in FILL, mem_addr=c_tag latched on entry and held stable.
  - mem_req drops the cycle after mem_ack.
  - Each mem_strobe drives c_rstrobe_d (WB) or c_wstrobe_d (FILL) combinationally and increments the beat counter.
  - The cache resets its own offset on any strobe-free cycle, so the burst must be contiguous. A gap after a partial burst resets the beat counter to 0 and waits for the burst to restart from beat 0, mem_req still held low. Memory resends the whole line.
  - On beat BEATS-1: counter to 0. WB -> IDLE, which re-evaluates and normally proceeds to FILL. FILL -> IDLE; a store completes at that edge with cpu_ready=1 that cycle (cache wdone); a load completes next cycle as a hit.
- FSCAN: if c_push, go to FWB (WB sequence, then return to FSCAN at the same index, now clean). Else index+1; at index NLINES-1 go to FCLR.
- FCLR: c_flush_all=1 and flush_done=1 for one cycle, then IDLE.
- Simultaneity: cpu_fault rising mid-burst is ignored until the burst ends. flush_req during WB/FILL waits for IDLE. mem_strobe outside WB/FILL/FWB is ignored.
- Reset mid-burst: immediate return to IDLE; the cache line stays invalid or dirty as the cache leaves it.

Optional Feature:
- Macro DCACHE_CTRL_TIMEOUT_EN.
- Enabled: a TO_BITS watchdog counts cycles without mem_strobe while in WB/FILL/FWB. On saturation, drop mem_req and zero the beat counter. CPU states return to IDLE with cpu_ready=cpu_err=1; the flush walk aborts to FCLR (invalidate all, flush_done pulse).
- Disabled: wait indefinitely; cpu_err only from cpu_fault.

Test Plan:
- Reset, then read hit on a valid line at 0x000010 -> cpu_ready in the same cycle, mem_req never asserted.
- Read miss, clean line, addr 0x000120 -> mem_req, mem_wr=0, mem_addr=0x48. Ack, then 8 strobes -> 8 c_wstrobe_d, then cpu_ready one cycle after the last beat.
- Store miss on dirty line tag 0x0030 -> WB burst of 8 c_rstrobe_d at the old tag, then FILL at the new tag. cpu_ready coincides with the 8th fill beat; the line ends dirty.
- Fill burst with strobe gap after beat 3, then 8 contiguous strobes -> counter restarts, exactly one completion, data from the second burst.
- flush_req with lines 1 and 3 dirty -> two WB bursts, index 1 then 3, then c_flush_all for one cycle and a flush_done pulse. All later accesses miss.
- TIMEOUT_EN, TO_BITS=6: fill with no strobes -> cpu_ready+cpu_err 64 cycles after ack, mem_req low, state IDLE.
